// File: rtl/processador_multiciclo.sv
// Multicycle 16-bit processor: eight registers, IR, A/G adder-subtractor around one shared bus.
// Tstep advances on the rising edge; all datapath registers load on the falling edge.
module processador_multiciclo (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] DIN,
  input  logic        Run,
  output logic        Done,
  output logic [15:0] BusWires
);
  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  logic [1:0]  Tstep, tstep_nxt;
  logic [8:0]  ir_q;
  logic [15:0] r_q [8];
  logic [15:0] a_q, g_q, bus, alu;
  logic [2:0]  op, rx, ry, r_idx;
  logic [7:0]  r_load;
  logic        ir_in, a_in, g_in, r_in, sel_din, sel_g, sel_r, sub_op;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  always_comb begin
    ir_in     = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    r_in      = 1'b0;
    sel_din   = 1'b0;
    sel_g     = 1'b0;
    sel_r     = 1'b0;
    sub_op    = 1'b0;
    r_idx     = rx;
    Done      = 1'b0;
    tstep_nxt = T0;
    case (Tstep)
      T0: begin
        ir_in     = 1'b1;
        sel_din   = 1'b1;
        tstep_nxt = Run ? T1 : T0;
      end
      T1: begin
        case (op)
          3'b000: begin
            sel_r = 1'b1;
            r_idx = ry;
            r_in  = 1'b1;
            Done  = 1'b1;
          end
          3'b001: begin
            sel_din = 1'b1;
            r_in    = 1'b1;
            Done    = 1'b1;
          end
          3'b010, 3'b011: begin
            sel_r     = 1'b1;
            r_idx     = rx;
            a_in      = 1'b1;
            tstep_nxt = T2;
          end
          default: Done = 1'b1;
        endcase
      end
      // T2/T3 are only reachable from an add/sub in T1
      T2: begin
        sel_r     = 1'b1;
        r_idx     = ry;
        g_in      = 1'b1;
        sub_op    = op[0];
        tstep_nxt = T3;
      end
      default: begin
        sel_g = 1'b1;
        r_in  = 1'b1;
        Done  = 1'b1;
      end
    endcase
  end

  always_comb begin
    bus = 16'h0000;
    if (sel_din)    bus = DIN;
    else if (sel_g) bus = g_q;
    else if (sel_r) bus = r_q[r_idx];
  end

  assign BusWires = bus;
  assign alu      = sub_op ? (a_q - bus) : (a_q + bus);
  assign r_load   = r_in ? (8'b0000_0001 << rx) : 8'b0000_0000;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) Tstep <= T0;
    else         Tstep <= tstep_nxt;
  end

  regn #(.W(9))  IR (.Clock(Clock), .Resetn(Resetn), .Rin(ir_in),     .D(bus[8:0]), .Q(ir_q));
  regn #(.W(16)) A  (.Clock(Clock), .Resetn(Resetn), .Rin(a_in),      .D(bus),      .Q(a_q));
  regn #(.W(16)) G  (.Clock(Clock), .Resetn(Resetn), .Rin(g_in),      .D(alu),      .Q(g_q));
  regn #(.W(16)) R0 (.Clock(Clock), .Resetn(Resetn), .Rin(r_load[0]), .D(bus),      .Q(r_q[0]));
  regn #(.W(16)) R1 (.Clock(Clock), .Resetn(Resetn), .Rin(r_load[1]), .D(bus),      .Q(r_q[1]));
  regn #(.W(16)) R2 (.Clock(Clock), .Resetn(Resetn), .Rin(r_load[2]), .D(bus),      .Q(r_q[2]));
  regn #(.W(16)) R3 (.Clock(Clock), .Resetn(Resetn), .Rin(r_load[3]), .D(bus),      .Q(r_q[3]));
  regn #(.W(16)) R4 (.Clock(Clock), .Resetn(Resetn), .Rin(r_load[4]), .D(bus),      .Q(r_q[4]));
  regn #(.W(16)) R5 (.Clock(Clock), .Resetn(Resetn), .Rin(r_load[5]), .D(bus),      .Q(r_q[5]));
  regn #(.W(16)) R6 (.Clock(Clock), .Resetn(Resetn), .Rin(r_load[6]), .D(bus),      .Q(r_q[6]));
  regn #(.W(16)) R7 (.Clock(Clock), .Resetn(Resetn), .Rin(r_load[7]), .D(bus),      .Q(r_q[7]));
endmodule

// Falling-edge register with load enable and asynchronous active-low clear.
module regn #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         Rin,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);
  always_ff @(negedge Clock or negedge Resetn) begin
    if (!Resetn)  Q <= '0;
    else if (Rin) Q <= D;
  end
endmodule

// File: tb/tb_processador_multiciclo.sv
// Bench for processador_multiciclo: directed instruction table, Run/reset corner cases,
// and random instructions checked against an instruction-level model of the register file.
module tb_processador_multiciclo;
  logic        Clock = 1'b0;
  logic        Resetn;
  logic [15:0] DIN;
  logic        Run;
  logic        Done;
  logic [15:0] BusWires;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] m_r [8];

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [15:0] imm;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  processador_multiciclo dut (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Run(Run), .Done(Done), .BusWires(BusWires)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] get_reg(input int i);
    case (i)
      0: return dut.R0.Q;
      1: return dut.R1.Q;
      2: return dut.R2.Q;
      3: return dut.R3.Q;
      4: return dut.R4.Q;
      5: return dut.R5.Q;
      6: return dut.R6.Q;
      default: return dut.R7.Q;
    endcase
  endfunction

  task automatic chk_all_regs(input string name);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_R%0d", name, i), get_reg(i), m_r[i]);
  endtask

  // Entered just after a rising edge with the core in T0; returns just after the
  // rising edge that ends the instruction.
  task automatic exec(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                      input logic [15:0] imm, input logic [6:0] hi);
    logic [15:0] word;
    logic [15:0] exp_bus [4];
    logic        exp_done [4];
    logic [15:0] res;
    int n;
    word = {hi, op, rx, ry};
    exp_bus[0] = word;
    exp_done[0] = 1'b0;
    res = m_r[rx];
    case (op)
      3'd0: begin n = 2; exp_bus[1] = m_r[ry]; res = m_r[ry]; end
      3'd1: begin n = 2; exp_bus[1] = imm;     res = imm;     end
      3'd2, 3'd3: begin
        n = 4;
        exp_bus[1] = m_r[rx];
        exp_bus[2] = m_r[ry];
        res = (op == 3'd2) ? m_r[rx] + m_r[ry] : m_r[rx] - m_r[ry];
        exp_bus[3] = res;
      end
      default: begin n = 2; exp_bus[1] = 16'h0000; end
    endcase
    for (int k = 1; k < 4; k++) exp_done[k] = (k == n - 1);
    for (int k = 0; k < n; k++) begin
      DIN = (k == 0) ? word : ((op == 3'd1) ? imm : 16'($urandom));
      Run = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #3;
      chk($sformatf("bus_op%0d_t%0d", op, k), BusWires, exp_bus[k]);
      chk($sformatf("done_op%0d_t%0d", op, k), {15'b0, Done}, {15'b0, exp_done[k]});
      if (k == 0) begin
        #2;
        #1;
        chk("ir_after_t0", {7'b0, dut.IR.Q}, {7'b0, word[8:0]});
        @(posedge Clock);
      end else begin
        @(posedge Clock);
      end
      #1;
    end
    m_r[rx] = res;
    chk("tstep_idle", {14'b0, dut.Tstep}, 16'h0000);
    chk_all_regs($sformatf("regs_op%0d", op));
  endtask

  initial begin
    logic [15:0] w;
    Resetn = 1'b0;
    DIN = 16'h0000;
    Run = 1'b0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;

    tbl.push_back('{3'd1, 3'd0, 3'd0, 16'd11,    16'd11});
    tbl.push_back('{3'd1, 3'd1, 3'd0, 16'd10,    16'd10});
    tbl.push_back('{3'd0, 3'd0, 3'd1, 16'd0,     16'd10});
    tbl.push_back('{3'd1, 3'd0, 3'd0, 16'd11,    16'd11});
    tbl.push_back('{3'd1, 3'd0, 3'd1, 16'd5,     16'd5});
    tbl.push_back('{3'd1, 3'd2, 3'd0, 16'd7,     16'd7});
    tbl.push_back('{3'd1, 3'd3, 3'd0, 16'd9,     16'd9});
    tbl.push_back('{3'd2, 3'd2, 3'd3, 16'd0,     16'd16});
    tbl.push_back('{3'd1, 3'd3, 3'd0, 16'd0,     16'd0});
    tbl.push_back('{3'd1, 3'd2, 3'd0, 16'd1,     16'd1});
    tbl.push_back('{3'd3, 3'd3, 3'd2, 16'd0,     16'hFFFF});
    tbl.push_back('{3'd1, 3'd5, 3'd0, 16'h8001,  16'h8001});
    tbl.push_back('{3'd2, 3'd5, 3'd5, 16'd0,     16'h0002});
    tbl.push_back('{3'd3, 3'd5, 3'd5, 16'd0,     16'h0000});
    tbl.push_back('{3'd1, 3'd7, 3'd0, 16'h1234,  16'h1234});
    tbl.push_back('{3'd0, 3'd7, 3'd7, 16'd0,     16'h1234});
    tbl.push_back('{3'd5, 3'd7, 3'd0, 16'hBEEF,  16'h1234});
    tbl.push_back('{3'd1, 3'd1, 3'd0, 16'd10,    16'd10});

    #11;
    chk("reset_tstep", {14'b0, dut.Tstep}, 16'h0000);
    chk("reset_done", {15'b0, Done}, 16'h0000);
    chk("reset_bus", BusWires, 16'h0000);
    chk("reset_ir", {7'b0, dut.IR.Q}, 16'h0000);
    chk_all_regs("reset");
    #1 Resetn = 1'b1;
    @(posedge Clock);
    #1;
    chk("post_reset_tstep", {14'b0, dut.Tstep}, 16'h0000);

    foreach (tbl[i]) begin
      exec(tbl[i].op, tbl[i].rx, tbl[i].ry, tbl[i].imm, 7'h00);
      chk($sformatf("tbl%0d_dest", i), get_reg(int'(tbl[i].rx)), tbl[i].exp);
    end

    // Run low: core holds in T0 with a valid add on DIN
    DIN = {7'h00, 3'b010, 3'd2, 3'd3};
    Run = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("runlow_tstep", {14'b0, dut.Tstep}, 16'h0000);
      chk("runlow_done", {15'b0, Done}, 16'h0000);
      @(posedge Clock);
      #1;
    end
    exec(3'd2, 3'd2, 3'd3, 16'd0, 7'h00);

    // Reset pulse during T2 of an add
    w = {7'h00, 3'b010, 3'd2, 3'd3};
    DIN = w;
    Run = 1'b1;
    @(posedge Clock);
    #1 DIN = 16'($urandom);
    @(posedge Clock);
    #1 chk("pre_reset_t2", {14'b0, dut.Tstep}, 16'h0002);
    #1 Resetn = 1'b0;
    #1;
    chk("midreset_tstep", {14'b0, dut.Tstep}, 16'h0000);
    chk("midreset_done", {15'b0, Done}, 16'h0000);
    chk("midreset_ir", {7'b0, dut.IR.Q}, 16'h0000);
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    chk_all_regs("midreset");
    Run = 1'b0;
    #4 Resetn = 1'b1;
    @(posedge Clock);
    #1;
    chk("after_reset_tstep", {14'b0, dut.Tstep}, 16'h0000);
    exec(3'd1, 3'd2, 3'd0, 16'h0042, 7'h00);
    exec(3'd2, 3'd2, 3'd2, 16'd0, 7'h00);
    chk("after_reset_add", get_reg(2), 16'h0084);

    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (i < 16) op = 3'd1;
      exec(op, 3'($urandom), 3'($urandom), 16'($urandom), 7'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
